regfile_operand_stage: RTL and testbench
========================================

Name: regfile_operand_stage

Overview:
- Parametrised successor of the decode-stage register file and operand mux.
- Holds the architectural integer registers and selects operand 1 and operand 2 from the register, PC or immediate sources.
- Adds a scoreboard, write-back bypass, a valid/ready handshake on both sides, and a one-entry registered output stage feeding execute.
- Sits between decode and execute; write-back drives the write port.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, 5, register address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode offers an instruction.
- dec_ready  out  1  stage accepts the instruction this cycle.
- op1_sel  in  2  operand 1 select: OP1_X=0, OP1_RS1=1, OP1_PC=2.
- op2_sel  in  3  operand 2 select: OP2_X=0, OP2_RS2=1, OP2_IMI=2, OP2_IMS=3, OP2_IMJ=4, OP2_IMU=5.
- rs1_addr, rs2_addr  in  AW  source register addresses.
- rd_addr  in  AW  destination register address.
- rd_we  in  1  instruction writes rd.
- pc, imm  in  XLEN  program counter and decoded immediate.
- ex_valid  out  1  output stage holds a valid instruction.
- ex_ready  in  1  execute consumes the instruction.
- op1_data, op2_data  out  XLEN  selected operands.
- ex_rd_addr  out  AW  registered rd_addr.
- ex_rd_we  out  1  registered rd_we.
- wb_en  in  1  write-back write enable.
- wb_addr  in  AW  write-back address.
- wb_data  in  XLEN  write-back data.

Behaviour:
- Reset:
  - All registers cleared to 0 and all busy bits cleared.
  - ex_valid=0; op1_data, op2_data, ex_rd_addr and ex_rd_we = 0.
  - Reset wins over every simultaneous event.
  - Reset mid-operation discards the held instruction and all pending scoreboard state.
- Register file:
  - Written when wb_en=1 and wb_addr!=0; data is visible to register reads from the next cycle.
  - Writes to register 0 are ignored; reads of register 0 always return 0.
- Operand read and bypass:
  - Read is combinational.
  - If wb_en=1, wb_addr==rs and rs!=0, the operand takes wb_data (same-cycle bypass).
- Operand select:
  - OP1_X gives 0, OP1_RS1 gives rs1 value, OP1_PC gives pc.
  - OP2_X gives 0, OP2_RS2 gives rs2 value; OP2_IMI, OP2_IMS, OP2_IMJ and OP2_IMU give imm.
  - Undefined select codes give 0, never X.
- Scoreboard (busy bit per register, one bit each):
  - hazard1 = (op1_sel==OP1_RS1) & busy[rs1] & !(wb_en & wb_addr==rs1).
  - hazard2 = (op2_sel==OP2_RS2) & busy[rs2] & !(wb_en & wb_addr==rs2).
  - hazard_w = rd_we & rd_addr!=0 & busy[rd] & !(wb_en & wb_addr==rd); this is the WAW case.
  - busy bit 0 is never set.
- Handshake:
  - dec_ready = (!ex_valid | ex_ready) & !hazard1 & !hazard2 & !hazard_w.
  - Accept = dec_valid & dec_ready.
  - On accept, the output registers load the selected operands, rd_addr and rd_we, and ex_valid=1. Latency is 1 cycle from accept to ex_valid.
  - If there is no accept and ex_ready=1, ex_valid drops to 0.
  - While ex_valid=1 and ex_ready=0, all outputs hold stable.
- Busy update each cycle:
  - Clear busy[wb_addr] when wb_en=1.
  - Then set busy[rd_addr] on accept when rd_we=1 and rd_addr!=0.
  - If both target the same register in one cycle, the set wins.
- dec_valid=0 while a hazard is present: no state change except write-back and the busy clear.

Decomposition:
- Package regfile_pkg holds:
  - the OP1_* and OP2_* select constants (shared with decode);
  - the XLEN and AW defaults;
  - a function operand_mux(sel, reg_value, pc, imm).
- One natural sub-module, rf_scoreboard: the busy vector, its set/clear logic and the three hazard outputs.
- The register array, bypass and output stage stay in the top module.

Test Plan:
- Reset, then issue op1=RS1 with rs1=3 and op2=IMI with imm=0x10 -> next cycle ex_valid=1, op1_data=0, op2_data=0x10; dec_ready stays 1.
- wb_en=1, wb_addr=0, wb_data=0xDEAD, then issue op1=RS1 with rs1=0 -> op1_data=0.
- Issue rd=5 with rd_we=1, then the next instruction reads rs1=5 -> dec_ready=0 until write-back. When wb_en=1, wb_addr=5 and wb_data=0x1234 arrive, the instruction is accepted that cycle with op1_data=0x1234 via bypass.
- WAW on rd=7:
  - Issue rd=7 with rd_we=1.
  - Issue a second instruction with rd=7 -> it stalls until wb to 7.
  - It is accepted in the write-back cycle, and busy[7] remains 1 after that cycle (set wins).
- Hold ex_ready=0 for 3 cycles with ex_valid=1 -> outputs stable and dec_ready=0. Raise ex_ready with dec_valid=1 -> back-to-back accept, and ex_valid stays 1.
- Assert reset while ex_valid=1 and busy[9]=1 -> next cycle ex_valid=0, all registers read 0, and an instruction reading rs1=9 is accepted immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the decode/execute operand stage: select encodings,
// width defaults and the operand source mux.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT   = 5;
  // Widest datapath the shared mux handles; narrower stages zero-extend in and truncate out.
  localparam int unsigned XLEN_MAX     = 64;

  typedef enum logic [1:0] {
    OP1_X   = 2'd0,
    OP1_RS1 = 2'd1,
    OP1_PC  = 2'd2
  } op1_sel_e;

  typedef enum logic [2:0] {
    OP2_X   = 3'd0,
    OP2_RS2 = 3'd1,
    OP2_IMI = 3'd2,
    OP2_IMS = 3'd3,
    OP2_IMJ = 3'd4,
    OP2_IMU = 3'd5
  } op2_sel_e;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_REG,
    SRC_PC,
    SRC_IMM
  } src_e;

  function automatic src_e op1_src(input logic [1:0] sel);
    case (sel)
      OP1_RS1: return SRC_REG;
      OP1_PC:  return SRC_PC;
      default: return SRC_ZERO;
    endcase
  endfunction

  function automatic src_e op2_src(input logic [2:0] sel);
    case (sel)
      OP2_RS2:                            return SRC_REG;
      OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU: return SRC_IMM;
      default:                            return SRC_ZERO;
    endcase
  endfunction

  function automatic logic [XLEN_MAX-1:0] operand_mux(
    input src_e                sel,
    input logic [XLEN_MAX-1:0] reg_value,
    input logic [XLEN_MAX-1:0] pc,
    input logic [XLEN_MAX-1:0] imm
  );
    case (sel)
      SRC_REG: return reg_value;
      SRC_PC:  return pc;
      SRC_IMM: return imm;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking in-flight destinations, with RAW and WAW
// hazard detection that is relieved by a same-cycle write-back.
module rf_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rs1_used,
  input  logic [AW-1:0] i_rs1_addr,
  input  logic          i_rs2_used,
  input  logic [AW-1:0] i_rs2_addr,
  input  logic          i_rd_we,
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_accept,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  output logic          o_hazard1,
  output logic          o_hazard2,
  output logic          o_hazard_w
);

  logic [NREGS-1:0] r_busy;
  logic             w_wb_rs1;
  logic             w_wb_rs2;
  logic             w_wb_rd;
  logic             w_rd_valid;

  assign w_wb_rs1   = i_wb_en && (i_wb_addr == i_rs1_addr);
  assign w_wb_rs2   = i_wb_en && (i_wb_addr == i_rs2_addr);
  assign w_wb_rd    = i_wb_en && (i_wb_addr == i_rd_addr);
  assign w_rd_valid = i_rd_we && (i_rd_addr != '0);

  assign o_hazard1  = i_rs1_used && r_busy[i_rs1_addr] && !w_wb_rs1;
  assign o_hazard2  = i_rs2_used && r_busy[i_rs2_addr] && !w_wb_rs2;
  assign o_hazard_w = w_rd_valid && r_busy[i_rd_addr] && !w_wb_rd;

  // Set is issued after clear so a new producer claiming the register being retired keeps it busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (i_wb_en) r_busy[i_wb_addr] <= 1'b0;
      if (i_accept && w_rd_valid) r_busy[i_rd_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_operand_stage.sv
// Integer register file with write-back bypass, operand selection, scoreboard
// interlock and a one-entry registered output toward execute.
module regfile_operand_stage
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [1:0]      op1_sel,
  input  logic [2:0]      op2_sel,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_we,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] op1_data,
  output logic [XLEN-1:0] op2_data,
  output logic [AW-1:0]   ex_rd_addr,
  output logic            ex_rd_we,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_ex_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [AW-1:0]   r_ex_rd_addr;
  logic            r_ex_rd_we;

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_hazard1;
  logic            w_hazard2;
  logic            w_hazard_w;
  logic            w_accept;

  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (rs1_addr != '0)
      w_rs1_val = (wb_en && wb_addr == rs1_addr) ? wb_data : r_regs[rs1_addr];
    if (rs2_addr != '0)
      w_rs2_val = (wb_en && wb_addr == rs2_addr) ? wb_data : r_regs[rs2_addr];
  end

  assign w_op1 = XLEN'(operand_mux(op1_src(op1_sel), XLEN_MAX'(w_rs1_val),
                                   XLEN_MAX'(pc), XLEN_MAX'(imm)));
  assign w_op2 = XLEN'(operand_mux(op2_src(op2_sel), XLEN_MAX'(w_rs2_val),
                                   XLEN_MAX'(pc), XLEN_MAX'(imm)));

  assign w_rs1_used = (op1_sel == OP1_RS1);
  assign w_rs2_used = (op2_sel == OP2_RS2);

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_used (w_rs1_used),
    .i_rs1_addr (rs1_addr),
    .i_rs2_used (w_rs2_used),
    .i_rs2_addr (rs2_addr),
    .i_rd_we    (rd_we),
    .i_rd_addr  (rd_addr),
    .i_accept   (w_accept),
    .i_wb_en    (wb_en),
    .i_wb_addr  (wb_addr),
    .o_hazard1  (w_hazard1),
    .o_hazard2  (w_hazard2),
    .o_hazard_w (w_hazard_w)
  );

  assign dec_ready = (!r_ex_valid || ex_ready) && !w_hazard1 && !w_hazard2 && !w_hazard_w;
  assign w_accept  = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid   <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_ex_rd_addr <= '0;
      r_ex_rd_we   <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid   <= 1'b1;
      r_op1        <= w_op1;
      r_op2        <= w_op2;
      r_ex_rd_addr <= rd_addr;
      r_ex_rd_we   <= rd_we;
    end else if (ex_ready) begin
      r_ex_valid   <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign op1_data   = r_op1;
  assign op2_data   = r_op2;
  assign ex_rd_addr = r_ex_rd_addr;
  assign ex_rd_we   = r_ex_rd_we;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Scenario bench for regfile_operand_stage: expected execute-side outputs are
// queued at issue and compared by a monitor when execute consumes them.
module tb_regfile_operand_stage;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            dec_valid = 1'b0;
  logic            dec_ready;
  logic [1:0]      op1_sel = '0;
  logic [2:0]      op2_sel = '0;
  logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
  logic            rd_we = 1'b0;
  logic [XLEN-1:0] pc = '0, imm = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b1;
  logic [XLEN-1:0] op1_data, op2_data;
  logic [AW-1:0]   ex_rd_addr;
  logic            ex_rd_we;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;

  typedef struct {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [AW-1:0]   rd;
    logic            we;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_operand_stage #(
    .XLEN  (32),
    .NREGS (32),
    .AW    (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .op1_sel    (op1_sel),
    .op2_sel    (op2_sel),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .rd_we      (rd_we),
    .pc         (pc),
    .imm        (imm),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .op1_data   (op1_data),
    .op2_data   (op2_data),
    .ex_rd_addr (ex_rd_addr),
    .ex_rd_we   (ex_rd_we),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  // Execute-side monitor: every consumed instruction must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: op1=%h op2=%h rd=%0d we=%b with nothing expected",
                 op1_data, op2_data, ex_rd_addr, ex_rd_we);
      end else begin
        e = q.pop_front();
        if ({op1_data, op2_data, ex_rd_addr, ex_rd_we} !== {e.op1, e.op2, e.rd, e.we}) begin
          n_fail++;
          $display("FAIL sb_output: got op1=%h op2=%h rd=%0d we=%b, want op1=%h op2=%h rd=%0d we=%b",
                   op1_data, op2_data, ex_rd_addr, ex_rd_we, e.op1, e.op2, e.rd, e.we);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dec_valid = 1'b0;
    wb_en     = 1'b0;
    ex_ready  = 1'b1;
    repeat (n) step();
  endtask

  task automatic set_instr(input logic [1:0] s1, input logic [2:0] s2,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [AW-1:0] ad, input logic we,
                           input logic [XLEN-1:0] p, input logic [XLEN-1:0] im);
    dec_valid = 1'b1;
    op1_sel   = s1;
    op2_sel   = s2;
    rs1_addr  = a1;
    rs2_addr  = a2;
    rd_addr   = ad;
    rd_we     = we;
    pc        = p;
    imm       = im;
  endtask

  task automatic expect_out(input logic [XLEN-1:0] o1, input logic [XLEN-1:0] o2,
                            input logic [AW-1:0] rd, input logic we);
    exp_t e;
    e.op1 = o1;
    e.op2 = o2;
    e.rd  = rd;
    e.we  = we;
    q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid);
    end
    n_checks++;
    if ({op1_data, op2_data, ex_rd_addr, ex_rd_we} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got op1=%h op2=%h rd=%0d we=%b want all 0",
               op1_data, op2_data, ex_rd_addr, ex_rd_we);
    end
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready);
    end
  endtask

  task automatic test_basic();
    step();
    set_instr(OP1_RS1, OP2_IMI, 5'd3, 5'd0, 5'd0, 1'b0, 32'h100, 32'h10);
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b want 1", dec_ready);
    end
    expect_out(32'h0, 32'h10, 5'd0, 1'b0);
    step();
    dec_valid = 1'b0;
    n_checks++;
    if ({ex_valid, op1_data, op2_data} !== {1'b1, 32'h0, 32'h10}) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%b op1=%h op2=%h want valid=1 op1=0 op2=10",
               ex_valid, op1_data, op2_data);
    end
    step();
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: got ex_valid=%b want 0", ex_valid);
    end
  endtask

  task automatic test_operand_select();
    logic [1:0]      s1 [5] = '{OP1_PC, 2'd3, OP1_RS1, OP1_X, OP1_PC};
    logic [2:0]      s2 [5] = '{OP2_IMU, 3'd7, OP2_RS2, OP2_IMJ, OP2_X};
    logic [XLEN-1:0] e1 [5] = '{32'h400, 32'h0, 32'h55AA, 32'h0, 32'h7FC};
    logic [XLEN-1:0] e2 [5] = '{32'hABC, 32'h0, 32'h55AA, 32'hABC, 32'h0};
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55AA;
    step();
    wb_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_instr(s1[i], s2[i], 5'd4, 5'd4, 5'd0, 1'b0, (i == 4) ? 32'h7FC : 32'h400, 32'hABC);
      @(negedge clk);
      n_checks++;
      if (dec_ready !== 1'b1) begin
        n_fail++; $display("FAIL select_ready[%0d]: got %b want 1", i, dec_ready);
      end
      expect_out(e1[i], e2[i], 5'd0, 1'b0);
      step();
    end
    idle(2);
  endtask

  task automatic test_r0();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    set_instr(OP1_RS1, OP2_RS2, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    expect_out(32'h0, 32'h0, 5'd0, 1'b0);
    step();
    wb_en = 1'b0;
    @(negedge clk);
    expect_out(32'h0, 32'h0, 5'd0, 1'b0);
    step();
    idle(2);
  endtask

  task automatic test_raw_bypass();
    set_instr(OP1_X, OP2_X, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    expect_out(32'h0, 32'h0, 5'd5, 1'b1);
    step();
    set_instr(OP1_RS1, OP2_X, 5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (dec_ready !== 1'b0) begin
        n_fail++; $display("FAIL raw_stall[%0d]: got dec_ready=%b want 0", i, dec_ready);
      end
      step();
    end
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_release: got dec_ready=%b want 1", dec_ready);
    end
    expect_out(32'h1234, 32'h0, 5'd0, 1'b0);
    step();
    wb_en = 1'b0;
    set_instr(OP1_RS1, OP2_RS2, 5'd5, 5'd4, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    expect_out(32'h1234, 32'h55AA, 5'd0, 1'b0);
    step();
    idle(2);
  endtask

  task automatic test_waw();
    set_instr(OP1_X, OP2_X, 5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    expect_out(32'h0, 32'h0, 5'd7, 1'b1);
    step();
    set_instr(OP1_PC, OP2_IMS, 5'd0, 5'd0, 5'd7, 1'b1, 32'h20, 32'h3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (dec_ready !== 1'b0) begin
        n_fail++; $display("FAIL waw_stall[%0d]: got dec_ready=%b want 0", i, dec_ready);
      end
      step();
    end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL waw_release: got dec_ready=%b want 1", dec_ready);
    end
    expect_out(32'h20, 32'h3, 5'd7, 1'b1);
    step();
    wb_en = 1'b0;
    set_instr(OP1_RS1, OP2_X, 5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b0) begin
      n_fail++; $display("FAIL waw_set_wins: got dec_ready=%b want 0 (r7 still busy)", dec_ready);
    end
    step();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h99;
    @(negedge clk);
    expect_out(32'h99, 32'h0, 5'd0, 1'b0);
    step();
    idle(2);
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b0;
    set_instr(OP1_PC, OP2_IMS, 5'd0, 5'd0, 5'd0, 1'b0, 32'hA0, 32'h5);
    @(negedge clk);
    expect_out(32'hA0, 32'h5, 5'd0, 1'b0);
    step();
    set_instr(OP1_PC, OP2_IMJ, 5'd0, 5'd0, 5'd0, 1'b0, 32'hB0, 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dec_ready, ex_valid, op1_data, op2_data} !== {1'b0, 1'b1, 32'hA0, 32'h5}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ready=%b valid=%b op1=%h op2=%h want ready=0 valid=1 op1=a0 op2=5",
                 i, dec_ready, ex_valid, op1_data, op2_data);
      end
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: got %b want 1", dec_ready);
    end
    expect_out(32'hB0, 32'h6, 5'd0, 1'b0);
    step();
    dec_valid = 1'b0;
    n_checks++;
    if ({ex_valid, op1_data} !== {1'b1, 32'hB0}) begin
      n_fail++; $display("FAIL b2b_valid: got valid=%b op1=%h want valid=1 op1=b0", ex_valid, op1_data);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    set_instr(OP1_X, OP2_X, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
    step();
    // Reset asserted alongside an offered instruction and a write-back; reset must win.
    reset = 1'b1;
    set_instr(OP1_X, OP2_X, 5'd0, 5'd0, 5'd11, 1'b1, 32'h0, 32'h0);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hFFFF;
    step();
    reset = 1'b0;
    wb_en = 1'b0;
    dec_valid = 1'b0;
    ex_ready = 1'b1;
    q.delete();
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ex_valid: got %b want 0", ex_valid);
    end
    set_instr(OP1_RS1, OP2_RS2, 5'd9, 5'd4, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_busy9: got dec_ready=%b want 1", dec_ready);
    end
    expect_out(32'h0, 32'h0, 5'd0, 1'b0);
    step();
    set_instr(OP1_RS1, OP2_RS2, 5'd11, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_busy11: got dec_ready=%b want 1", dec_ready);
    end
    expect_out(32'h0, 32'h0, 5'd0, 1'b0);
    step();
    set_instr(OP1_RS1, OP2_RS2, 5'd7, 5'd4, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    expect_out(32'h0, 32'h0, 5'd0, 1'b0);
    step();
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_select();
    test_r0();
    test_raw_bypass();
    test_waw();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d outstanding expectations want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
